sub_64bit: RTL and testbench

Registered 64-bit two's-complement subtractor for the Y86-64 ALU. It computes `ans = A - B` with signed-overflow detection. The subtract datapath is built as `A + ~B + 1` over a ripple chain of one-bit full adders. The ALU's operation mux selects this block's result and overflow flag for `subq` and the compare-style condition-code update.

---
 rtl/alu_pkg.sv | 8 +
 rtl/sub_64bit_if.sv | 15 +
 rtl/full_adder.sv | 16 +
 rtl/sub_64bit.sv | 48 ++++
 tb/tb_sub_64bit.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared Y86-64 ALU constants. The add, sub, and and xor blocks all take
// their word width and sign-bit position from here.
package alu_pkg;

  localparam int WORD_W   = 64;
  localparam int SIGN_BIT = WORD_W - 1;

endpackage : alu_pkg

// File: rtl/sub_64bit_if.sv
// Operand/result bundle for the registered 64-bit subtractor.
interface sub_64bit_if;
  import alu_pkg::*;

  // There is no valid/ready pair. Every rising clk edge accepts A/B, and
  // ans/overflow show the difference one cycle later. The pipe never stalls.
  logic [WORD_W-1:0] A;
  logic [WORD_W-1:0] B;
  logic [WORD_W-1:0] ans;
  logic              overflow;

  modport master (output A, output B, input ans, input overflow);
  modport slave  (input A, input B, output ans, output overflow);

endinterface : sub_64bit_if

// File: rtl/full_adder.sv
// One-bit gate-level full adder. It is the ripple cell of the ALU add/sub chains.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign sum  = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule : full_adder

// File: rtl/sub_64bit.sv
// Registered 64-bit two's-complement subtractor: ans = A + ~B + 1 over a
// ripple chain, plus a signed-overflow flag. Latency is one cycle.
module sub_64bit
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  sub_64bit_if.slave  bus
);

  logic [WORD_W-1:0] b_inv;
  logic [WORD_W-1:0] diff;
  logic [WORD_W:0]   c;
  logic              ovf;
  logic [WORD_W-1:0] ans_q;
  logic              ovf_q;

  assign b_inv = ~bus.B;
  assign c[0]  = 1'b1;

  for (genvar i = 0; i < WORD_W; i++) begin : g_fa
    full_adder u_fa (
      .a    (bus.A[i]),
      .b    (b_inv[i]),
      .cin  (c[i]),
      .sum  (diff[i]),
      .cout (c[i+1])
    );
  end

  // Carry into the sign bit disagrees with the carry out: the signed result wrapped.
  // c[WORD_W] (the inverted borrow) is used only here.
  assign ovf = c[SIGN_BIT] ^ c[WORD_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ans_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      ans_q <= diff;
      ovf_q <= ovf;
    end
  end

  assign bus.ans      = ans_q;
  assign bus.overflow = ovf_q;

endmodule : sub_64bit

// File: tb/tb_sub_64bit.sv
// Bench for sub_64bit. Directed cases and a random sweep push expected
// {overflow, ans} words. A monitor pops and compares after every edge.
module tb_sub_64bit;

  localparam int W = 65;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [W-1:0] exp_q[$];

  sub_64bit_if bus ();

  sub_64bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // Computes the exact difference in 65-bit signed arithmetic, then range-checks it.
  function automatic logic [W-1:0] ref_sub(input logic [63:0] a, input logic [63:0] b);
    logic signed [64:0] wa;
    logic signed [64:0] wb;
    logic signed [64:0] wide;
    longint             sa;
    longint             sb;
    logic               ovf;
    sa   = a;
    sb   = b;
    wa   = sa;
    wb   = sb;
    wide = wa - wb;
    ovf  = (wide > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (wide < 65'sh1_8000_0000_0000_0000);
    return {ovf, wide[63:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_exp(input logic r, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] e_ans, input logic e_ovf);
    @(negedge clk);
    rst_n = r;
    bus.A = a;
    bus.B = b;
    exp_q.push_back({e_ovf, e_ans});
  endtask

  task automatic drive(input logic r, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    rst_n = r;
    bus.A = a;
    bus.B = b;
    exp_q.push_back(r ? ref_sub(a, b) : {W{1'b0}});
  endtask

  function automatic logic [63:0] pick_operand();
    logic [63:0] v;
    case ($urandom_range(0, 6))
      0:       v = 64'h8000_0000_0000_0000;
      1:       v = 64'h7FFF_FFFF_FFFF_FFFF;
      2:       v = '1;
      3:       v = '0;
      4:       v = 64'($urandom_range(0, 1000));
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    logic [W-1:0] exp;
    int           n;
    n = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        checks++;
        if ({bus.overflow, bus.ans} !== exp) begin
          failures++;
          $display("FAIL result#%0d: got ans=%0d ovf=%b, required ans=%0d ovf=%b",
                   n, $signed(bus.ans), bus.overflow, $signed(exp[63:0]), exp[64]);
        end
        n++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] neg_a;
    logic [63:0] neg_ans;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.A    = 64'd5;
    bus.B    = 64'd3;

    // Reset held for two edges, then release.
    drive_exp(1'b0, 64'd5, 64'd3, 64'd0, 1'b0);
    drive_exp(1'b0, 64'd5, 64'd3, 64'd0, 1'b0);
    drive_exp(1'b1, 64'd5, 64'd3, 64'd2, 1'b0);

    // Overflow corners.
    drive_exp(1'b1, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    drive_exp(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, '1, 64'h8000_0000_0000_0000, 1'b1);

    // Small operands with a negative result, then back-to-back mixed signs.
    drive_exp(1'b1, 64'd69, 64'd420, -64'sd351, 1'b0);
    drive_exp(1'b1, 64'd43364756, -64'sd666, 64'd43365422, 1'b0);
    neg_a   = -64'sd11892789183;
    neg_ans = -64'sd11961542858;
    drive_exp(1'b1, neg_a, 64'd68753675, neg_ans, 1'b0);

    // B = -2^63 edge.
    drive_exp(1'b1, 64'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);
    drive_exp(1'b1, '1, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);

    // A == B gives zero.
    drive_exp(1'b1, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'd0, 1'b0);

    // Random sweep with one mid-stream reset.
    for (int i = 0; i < 300; i++) begin
      a = pick_operand();
      b = pick_operand();
      drive((i == 150) ? 1'b0 : 1'b1, a, b);
    end

    // Drain the scoreboard; every pushed expectation must have been consumed.
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sub_64bit
